// File: rtl/count_display_pkg.sv
// Shared definitions for the count_display block.
//   conv_state_t : conversion FSM states of the binary-to-BCD engine
//   SEG_BLANK    : segment pattern with every segment off (active-low)
//   AN_OFF       : anode pattern with every digit off (active-low)
//   seg_lut      : active-low {g,f,e,d,c,b,a} encodings of digits 0-9
//   seg_encode   : digit to segment pattern, blank for non-decimal nibbles
package count_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] seg_lut [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        if (digit > 4'd9) begin
            return SEG_BLANK;
        end
        return seg_lut[digit];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one iteration per clock.
//   clk   : system clock
//   reset : synchronous active-high reset, aborts any conversion
//   bin   : 8-bit binary input, captured when start is accepted
//   start : conversion request, honoured only in IDLE
//   busy  : high while in SHIFT or COMMIT
//   bcd   : {hundreds, tens, units}, valid while done is high
//   done  : high for the single COMMIT cycle
module bin2bcd_seq
    import count_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  bin,
    input  logic        start,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        done
);

    conv_state_t  state_reg;
    logic [7:0]   shreg_reg;
    logic [11:0]  acc_reg;
    logic [3:0]   iter_reg;
    logic [11:0]  adj;

    // Add-3 correction on each BCD nibble ahead of the shift.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5)
                                  ? acc_reg[gi*4 +: 4] + 4'd3
                                  : acc_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            shreg_reg <= 8'd0;
            acc_reg   <= 12'd0;
            iter_reg  <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shreg_reg <= bin;
                        acc_reg   <= 12'd0;
                        iter_reg  <= 4'd0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc_reg, shreg_reg} <= {adj[10:0], shreg_reg, 1'b0};
                    iter_reg <= iter_reg + 4'd1;
                    if (iter_reg == 4'd7) begin
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == COMMIT);
    assign bcd  = acc_reg;

endmodule

// File: rtl/count_display.sv
// Counter value to 3-digit multiplexed seven-segment display.
//   clk   : system clock
//   reset : synchronous active-high reset
//   value : 8-bit unsigned value to display
//   load  : sample strobe, ignored while busy
//   busy  : conversion in progress
//   seg   : active-low segments {g,f,e,d,c,b,a}
//   an    : active-low anodes, an[0] is units, an[3] unused (off)
//   dp    : active-low decimal point, always off
module count_display
    import count_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [11:0]   bcd;
    logic          done;
    logic [3:0]    hundreds_reg, tens_reg, units_reg;
    logic [PW-1:0] presc_reg;
    logic [1:0]    digit_sel_reg, digit_sel_next;
    logic          wrap;
    logic [3:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .bin   (value),
        .start (load),
        .busy  (busy),
        .bcd   (bcd),
        .done  (done)
    );

    assign wrap           = (presc_reg == PW'(REFRESH_DIV - 1));
    assign digit_sel_next = (digit_sel_reg == 2'd2) ? 2'd0 : digit_sel_reg + 2'd1;

    // Pattern for the slot about to be entered, so anode and segments
    // switch together on the wrap edge.
    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        case (digit_sel_next)
            2'd0: begin
                an_next  = 4'b1110;
                seg_next = seg_encode(units_reg);
            end
            2'd1: begin
                if (hundreds_reg != 4'd0 || tens_reg != 4'd0) begin
                    an_next  = 4'b1101;
                    seg_next = seg_encode(tens_reg);
                end
            end
            2'd2: begin
                if (hundreds_reg != 4'd0) begin
                    an_next  = 4'b1011;
                    seg_next = seg_encode(hundreds_reg);
                end
            end
            default: begin
                an_next  = AN_OFF;
                seg_next = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hundreds_reg  <= 4'd0;
            tens_reg      <= 4'd0;
            units_reg     <= 4'd0;
            presc_reg     <= '0;
            digit_sel_reg <= 2'd0;
            an_reg        <= 4'b1110;
            seg_reg       <= seg_lut[0];
        end else begin
            if (done) begin
                hundreds_reg <= bcd[11:8];
                tens_reg     <= bcd[7:4];
                units_reg    <= bcd[3:0];
            end
            if (wrap) begin
                presc_reg     <= '0;
                digit_sel_reg <= digit_sel_next;
                an_reg        <= an_next;
                seg_reg       <= seg_next;
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = 1'b1;

endmodule

// File: doc/count_display.md
Name: count_display

Overview:
- Downstream consumer of the 8-bit event counter.
- Samples the counter value on a strobe and converts it to three BCD digits with a sequential double-dabble engine.
- Drives a 4-digit common-anode seven-segment display by time-multiplexing, with leading-zero blanking.
- Sits between the counter output and the board display pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. Must be at least 2; benches use 4.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- value, input, 8: unsigned binary value from the counter.
- load, input, 1: sample strobe; accepted only when busy=0.
- busy, output, 1: conversion in progress; high in SHIFT and COMMIT states.
- seg, output, 7: active-low segments, {g,f,e,d,c,b,a}.
- an, output, 4: active-low digit anodes; an[0] is the units digit.
- dp, output, 1: active-low decimal point; constant 1 (off).

Behaviour:
- Reset (one clk edge with reset=1):
  - state=IDLE, busy=0.
  - Shift register, BCD accumulator, iteration counter and displayed digits all cleared to 0.
  - Prescaler=0, digit_sel=0.
  - an=4'b1110, seg=7'b1000000 (digit "0"), dp=1.
- Reset priority: reset beats load and every other event. A reset mid-conversion aborts it; the displayed digits return to 0.
- Conversion FSM:
  - IDLE: on an edge with load=1, capture value into the 8-bit shift register, clear the 12-bit BCD accumulator and the iteration counter, go to SHIFT.
  - SHIFT: each edge performs one double-dabble iteration. First add 3 to every BCD nibble that is >=5, then shift {bcd, shreg} left by 1 and increment the iteration counter. After the 8th iteration, go to COMMIT.
  - COMMIT: copy the accumulator into the displayed-digit registers (hundreds, tens, units), go to IDLE.
  - Latency: load sampled at edge N; digits updated at edge N+9. busy is high from after edge N through edge N+9, then low.
  - load while busy=1 is ignored and not queued.
  - The displayed digits hold their old value throughout a conversion; there are no intermediate glitches.
- Refresh:
  - The prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_sel advances 0 → 1 → 2 → 0 (a 3-slot scan).
  - an[3] is always 1.
- Slot outputs:
  - Slot k drives an with only bit k low, and seg with the encoding of digit k.
  - The outputs are registered and update on the same edge that digit_sel changes, so an and seg always change together.
- Leading-zero blanking:
  - Hundreds is blanked when it is 0.
  - Tens is blanked when both hundreds and tens are 0.
  - Units is never blanked.
  - A blanked slot drives an=4'b1111 and seg=7'b1111111.
- Segment encodings 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Width rules:
  - 255 is the maximum input, so the hundreds digit is at most 2.
  - The 12-bit accumulator never overflows.
  - The iteration counter is 4 bits wide.

Decomposition:
- Package count_display_pkg holds:
  - the conv_state_t enum {IDLE, SHIFT, COMMIT};
  - the constants SEG_BLANK=7'b1111111 and AN_OFF=4'b1111;
  - a seg_lut constant array of the 10 encodings.
- Sub-module bin2bcd_seq holds the FSM, shift register and accumulator, with ports clk, reset, bin[7:0], start, busy, bcd[11:0], done.
- The top level holds the digit registers, prescaler, scan logic and blanking.

Test Plan:
- Reset held 2 cycles → an=1110, seg=1000000, dp=1, busy=0; after release with REFRESH_DIV=4, slots 1 and 2 show an=1111, seg=1111111.
- load with value=255 → busy high for exactly 9 cycles; the scan then shows an=1110/seg=0010010, an=1101/seg=0010010, an=1011/seg=0100100 ("255").
- value=7 → units slot shows seg=1111000 with an=1110; tens and hundreds slots are blanked (an=1111, seg=1111111).
- load value=100, then load value=42 three cycles later → the second strobe is ignored; the display shows 0, 0, 1 (tens shown because hundreds is nonzero).
- load value=200, reset asserted on the 4th busy cycle → the next cycle has busy=0 and the display shows only "0"; a subsequent load of 42 shows seg 0011001 / 0100100 with hundreds blanked.
- load value=0 → units shows 1000000; tens and hundreds are blanked; wrap-around of the counter from 255 to 0 displays correctly.
